// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle for the round-robin priority encoder.
// master drives req/mode/out_ready; slave returns out_valid/out_idx/grant.
interface prio_encoder_rr_if #(
  parameter int N = 8
) ();
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] grant;

  modport master (
    output req, mode, out_ready,
    input  out_valid, out_idx, grant
  );

  modport slave (
    input  req, mode, out_ready,
    output out_valid, out_idx, grant
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder, fixed or round-robin, with valid/ready output.
// Ports: clk, rst (async high), bus (slave: req, mode, out_ready -> out_valid, out_idx, grant).
module prio_encoder_rr #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  prio_encoder_rr_if.slave bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state_q;
  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [W-1:0] rr_q;
  logic [N-1:0] grant_q;

  logic         accept;
  logic         capture;
  logic [W-1:0] succ;
  logic [W-1:0] start;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] idx_d;
  logic [N-1:0] grant_d;

  assign accept  = (state_q == HOLD) & bus.out_ready;
  assign capture = (state_q == IDLE) | accept;

  // explicit wrap so non-power-of-2 N never reaches index N
  assign succ  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
  assign start = accept ? succ : rr_q;

  // later (higher) set bits overwrite earlier ones
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) fix_idx = W'(i);
    end
  end

  // walk offsets downwards so the smallest offset from start wins
  always_comb begin
    int           j;
    logic [W-1:0] jj;
    rr_idx = '0;
    j      = 0;
    jj     = '0;
    for (int o = N - 1; o >= 0; o--) begin
      j = int'(start) + o;
      if (j >= N) j = j - N;
      jj = W'(j);
      if (bus.req[jj]) rr_idx = jj;
    end
  end

  assign idx_d   = bus.mode ? rr_idx : fix_idx;
  assign grant_d = N'(1) << idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      if (accept && bus.mode) rr_q <= succ;
      if (capture) begin
        if (|bus.req) begin
          state_q <= HOLD;
          valid_q <= 1'b1;
          idx_q   <= idx_d;
          grant_q <= grant_d;
        end else begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          grant_q <= '0;
        end
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.grant     = grant_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr at N=8, N=4 and N=5.
// A behavioural model queues expected outputs each edge; they are popped after the edge.
module tb_prio_encoder_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_encoder_rr_if #(.N(8)) b8 ();
  prio_encoder_rr_if #(.N(4)) b4 ();
  prio_encoder_rr_if #(.N(5)) b5 ();

  prio_encoder_rr #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  prio_encoder_rr #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  prio_encoder_rr #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));

  logic [7:0] r_in [3];
  logic       m_in [3];
  logic       y_in [3];

  assign b8.req = r_in[0];
  assign b4.req = r_in[1][3:0];
  assign b5.req = r_in[2][4:0];
  assign b8.mode = m_in[0];
  assign b4.mode = m_in[1];
  assign b5.mode = m_in[2];
  assign b8.out_ready = y_in[0];
  assign b4.out_ready = y_in[1];
  assign b5.out_ready = y_in[2];

  typedef struct {
    int         k;
    logic       v;
    int         idx;
    logic [7:0] g;
    int         p;
  } exp_t;

  exp_t sb[$];
  int   nn [3] = '{8, 4, 5};
  logic mv [3];
  int   mi [3];
  int   mp [3];
  int   msb_tab [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0;
      mi[k] = 0;
      mp[k] = 0;
    end
  endtask

  task automatic expect_now();
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.k   = k;
      e.v   = mv[k];
      e.idx = mi[k];
      e.g   = mv[k] ? 8'(1 << mi[k]) : 8'h00;
      e.p   = mp[k];
      sb.push_back(e);
    end
  endtask

  // next state of every instance from the inputs about to be sampled
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int         n;
      int         s;
      int         w;
      int         j;
      bit         acc;
      bit         hit;
      logic [7:0] r;
      n   = nn[k];
      r   = r_in[k] & 8'((1 << n) - 1);
      acc = mv[k] && y_in[k];
      s   = acc ? (mi[k] + 1) % n : mp[k];
      if (acc && m_in[k]) mp[k] = (mi[k] + 1) % n;
      if (!mv[k] || acc) begin
        hit = 1'b0;
        w   = 0;
        if (m_in[k]) begin
          for (int off = 0; off < n; off++) begin
            j = (s + off) % n;
            if (!hit && r[j]) begin
              hit = 1'b1;
              w   = j;
            end
          end
        end else begin
          for (int b = n - 1; b >= 0; b--) begin
            if (!hit && r[b]) begin
              hit = 1'b1;
              w   = b;
            end
          end
        end
        mv[k] = hit;
        if (hit) mi[k] = w;
      end
    end
    expect_now();
  endtask

  task automatic drain(string tag);
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] ov;
      logic [31:0] oi;
      logic [31:0] og;
      logic [31:0] op;
      e = sb.pop_front();
      ov = '0; oi = '0; og = '0; op = '0;
      case (e.k)
        0: begin
          ov = 32'(b8.out_valid); oi = 32'(b8.out_idx);
          og = 32'(b8.grant);     op = 32'(u8.rr_q);
        end
        1: begin
          ov = 32'(b4.out_valid); oi = 32'(b4.out_idx);
          og = 32'(b4.grant);     op = 32'(u4.rr_q);
        end
        default: begin
          ov = 32'(b5.out_valid); oi = 32'(b5.out_idx);
          og = 32'(b5.grant);     op = 32'(u5.rr_q);
        end
      endcase
      chk($sformatf("%s.valid[%0d]", tag, e.k), ov, 32'(e.v));
      chk($sformatf("%s.idx[%0d]", tag, e.k), oi, 32'(e.idx));
      chk($sformatf("%s.grant[%0d]", tag, e.k), og, 32'(e.g));
      chk($sformatf("%s.ptr[%0d]", tag, e.k), op, 32'(e.p));
    end
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    drain(tag);
  endtask

  // called just after an edge: assert mid-cycle, release before next edge
  task automatic pulse_rst(string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    expect_now();
    drain(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      r_in[k] = '0;
      m_in[k] = 1'b0;
      y_in[k] = 1'b0;
    end
    rst = 1'b1;
    #1;
    model_reset();
    expect_now();
    drain("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    r_in[0] = 8'h26; y_in[0] = 1'b1;
    step("t1");
    chk("t1_idx", 32'(b8.out_idx), 32'd5);
    chk("t1_grant", 32'(b8.grant), 32'h20);
    r_in[0] = 8'h00;
    step("t1_end");

    y_in[1] = 1'b1;
    for (int v = 0; v < 16; v++) begin
      r_in[1] = 8'(v);
      repeat (20) step("t2");
      chk("t2_valid", 32'(b4.out_valid), 32'(v != 0));
      if (v != 0) chk("t2_idx", 32'(b4.out_idx), 32'(msb_tab[v]));
    end
    r_in[1] = 8'h00;
    step("t2_end");

    pulse_rst("t3_rst");
    r_in[0] = 8'hFF; m_in[0] = 1'b1; y_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("t3");
      chk("t3_idx", 32'(b8.out_idx), 32'(i % 8));
      chk("t3_valid", 32'(b8.out_valid), 32'd1);
    end

    r_in[0] = 8'h00;
    step("t4_idle");
    r_in[0] = 8'h08; y_in[0] = 1'b0;
    step("t4_cap");
    r_in[0] = 8'h80; m_in[0] = 1'b0;
    step("t4_hold");
    m_in[0] = 1'b1;
    step("t4_hold");
    m_in[0] = 1'b0; r_in[0] = 8'h30;
    step("t4_hold");
    chk("t4_frozen_idx", 32'(b8.out_idx), 32'd3);
    chk("t4_frozen_grant", 32'(b8.grant), 32'h08);
    y_in[0] = 1'b1;
    step("t4_rel");
    chk("t4_new_idx", 32'(b8.out_idx), 32'd5);
    r_in[0] = 8'h00;
    step("t4_end");

    m_in[2] = 1'b1; y_in[2] = 1'b1; r_in[2] = 8'h10;
    step("t5_a");
    chk("t5_idx4", 32'(b5.out_idx), 32'd4);
    r_in[2] = 8'h03;
    step("t5_b");
    chk("t5_wrap_idx", 32'(b5.out_idx), 32'd0);
    chk("t5_wrap_ptr", 32'(u5.rr_q), 32'd0);
    r_in[2] = 8'h00;
    step("t5_end");

    r_in[0] = 8'h40; m_in[0] = 1'b0; y_in[0] = 1'b0;
    step("t6_cap");
    chk("t6_idx", 32'(b8.out_idx), 32'd6);
    pulse_rst("t6_rst");
    r_in[0] = 8'h41; m_in[0] = 1'b1; y_in[0] = 1'b1;
    step("t6_after");
    chk("t6_idx0", 32'(b8.out_idx), 32'd0);

    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++) begin
        r_in[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        m_in[k] = 1'($urandom_range(0, 1));
        y_in[k] = ($urandom_range(0, 3) != 0);
      end
      if (n % 97 == 50) pulse_rst("rnd_rst");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
